rd_beat_fetch: RTL
==================

Name: rd_beat_fetch

Overview:
- Downstream slave of the rd/ds/ws read-control FSM. It consumes rd (read request level) and ds (beat-done strobe), and produces ws (wait state).
- For each requested beat it issues one memory read, captures the returned word into a small FIFO, and presents the words on a valid/ready output stream.
- It sits between the control FSM, a simple req/ack memory port, and the downstream data consumer.

Parameters:
- DW, 8, memory/output data width.
- AW, 8, memory address width; address counter wraps at 2**AW.
- DEPTH, 4, output FIFO depth; power of 2, >= 2.
- TIMEOUT, 15, maximum cycles REQ waits for mem_ack before aborting the beat.

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- rd, input, 1, read request level from control FSM.
- ds, input, 1, one-cycle beat-done strobe from control FSM.
- ws, output, 1, wait state; 0 only while a captured beat is ready for acknowledge.
- addr_clr, input, 1, synchronous clear of address counter to 0; honoured only in IDLE.
- mem_req, output, 1, memory read request, held until ack or timeout.
- mem_addr, output, AW, read address; equals addr_q.
- mem_ack, input, 1, memory ack; mem_rdata is valid in the same cycle.
- mem_rdata, input, DW, memory read data.
- out_valid, output, 1, FIFO not empty.
- out_ready, input, 1, consumer accepts head word when out_valid=1.
- out_data, output, DW, FIFO head word.
- err, output, 1, sticky timeout flag; cleared only by rst.
- fifo_cnt, output, $clog2(DEPTH)+1, FIFO occupancy.

Behaviour:
- Reset values: state=IDLE, ws=1, mem_req=0, mem_addr=0, out_valid=0, out_data=0, err=0, fifo_cnt=0, timeout counter=0. Reset mid-operation discards the outstanding request and all FIFO contents.
- FSM states: IDLE, REQ, RDY.
- IDLE:
  - ws=1, mem_req=0.
  - addr_clr=1 sets addr_q<=0.
  - rd=1 and fifo_cnt<DEPTH -> REQ.
  - rd=1 with FIFO full -> stay in IDLE (ws stays 1).
- REQ:
  - mem_req=1, mem_addr=addr_q, ws=1, timeout counter increments each cycle.
  - mem_ack=1 -> push mem_rdata, addr_q<=addr_q+1 (wraps mod 2**AW), counter<=0, next state RDY.
  - rd=0 before ack -> abort to IDLE, no push, addr_q unchanged. Ack in that same cycle takes priority: push and go to RDY.
  - Counter reaches TIMEOUT with no ack -> err<=1, no push, addr_q unchanged, counter<=0, next state RDY. This lets the controller complete rather than hang.
- RDY:
  - ws=0, mem_req=0.
  - ds=1 -> IDLE.
  - rd=0 without ds -> IDLE.
  - ds=1 while rd=0 -> IDLE (single transition).
- Latency:
  - rd rising in IDLE with space -> mem_req=1 on the next cycle.
  - mem_ack in cycle N -> ws=0 and the word written at the edge ending N; out_valid=1 in N+1 if the FIFO was empty.
  - Minimum beat period: IDLE -> REQ -> RDY -> IDLE, 3 cycles, with ack on the first REQ cycle and ds on the first RDY cycle.
- ds outside RDY is ignored.
- FIFO:
  - Push only from REQ on ack; push is never attempted when full, because entry into REQ is gated.
  - Pop when out_valid & out_ready.
  - Push and pop in the same cycle: fifo_cnt unchanged, order preserved. This includes fifo_cnt=1, where the pushed word becomes the head next cycle with out_valid held at 1.
  - Pointers wrap mod DEPTH.
  - out_data is the registered head; its value when out_valid=0 is don't-care, except 0 after reset.
- Back-pressure: a full FIFO holds the FSM in IDLE with ws=1 until a pop frees an entry. The controller sees continuous wait states.

Test Plan:
- Reset/idle: assert rst mid-REQ with 2 words buffered -> ws=1, mem_req=0, fifo_cnt=0, err=0, mem_addr=0 immediately and after release.
- Single beat: rd=1, mem_ack on first REQ cycle with rdata=0xA5 -> mem_addr=0x00, ws=0 next cycle; ds pulse -> IDLE; out_data=0xA5, out_valid=1; mem_addr=0x01.
- Back-pressure: out_ready=0, 5 beats requested with DEPTH=4 -> 4 words 0x10..0x13 buffered, fifo_cnt=4, ws stays 1 in IDLE. Pop once -> 5th beat issues at addr 0x04.
- Timeout: rd=1, mem_ack never asserted -> mem_req high 15 cycles, then err=1, ws=0, no push, mem_addr unchanged. err stays 1 through later good beats.
- Wrap/clear: addr_q=0xFF, one beat -> mem_addr becomes 0x00. addr_clr in IDLE at addr 0x37 -> 0x00; addr_clr during REQ has no effect.
- Abort and simultaneity:
  - rd dropped in REQ without ack -> IDLE, no push.
  - rd dropped in the same cycle as ack -> push, RDY.
  - Push+pop at fifo_cnt=1 -> fifo_cnt stays 1, new word at head.

Source files
------------

// File: rtl/rd_beat_fetch.sv
// Read-beat fetcher: turns rd/ds beat handshakes into req/ack memory reads
// and buffers the returned words in a small FIFO on a valid/ready stream.
module rd_beat_fetch #(
   parameter int unsigned DW      = 8,
   parameter int unsigned AW      = 8,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rd,
   input  logic                       ds,
   output logic                       ws,
   input  logic                       addr_clr,
   output logic                       mem_req,
   output logic [AW-1:0]              mem_addr,
   input  logic                       mem_ack,
   input  logic [DW-1:0]              mem_rdata,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DW-1:0]              out_data,
   output logic                       err,
   output logic [$clog2(DEPTH):0]     fifo_cnt
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, REQ, RDY} state_e;

   state_e          state_q, state_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic            err_q, err_d;
   logic            ws_q, ws_d;
   logic            mem_req_q, mem_req_d;
   logic            push_c, pop_c;

   logic [DW-1:0]   mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   head_q, head_d;
   logic            valid_q, valid_d;

   // Beat sequencing: next state, address, timeout and error tracking
   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      addr_d  = addr_q;
      err_d   = err_q;
      push_c  = 1'b0;
      case (state_q)
         IDLE: begin
            tmo_d = '0;
            if (addr_clr) addr_d = '0;
            if (rd && (cnt_q < CW'(DEPTH))) state_d = REQ;
         end
         REQ: begin
            if (mem_ack) begin
               push_c  = 1'b1;
               addr_d  = addr_q + AW'(1);
               tmo_d   = '0;
               state_d = RDY;
            end else if (!rd) begin
               tmo_d   = '0;
               state_d = IDLE;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               // Give up on this beat so the controller can still complete it
               err_d   = 1'b1;
               tmo_d   = '0;
               state_d = RDY;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         RDY: begin
            if (ds || !rd) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      ws_d      = (state_d != RDY);
      mem_req_d = (state_d == REQ);
   end

   // FIFO bookkeeping with a registered head word
   always_comb begin
      pop_c    = valid_q & out_ready;
      wr_ptr_d = push_c ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop_c  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      cnt_d    = cnt_q;
      case ({push_c, pop_c})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
      head_d = head_q;
      if (pop_c) begin
         if (cnt_q == CW'(1)) begin
            if (push_c) head_d = mem_rdata;
         end else begin
            head_d = mem_q[rd_ptr_q + PW'(1)];
         end
      end else if (push_c && (cnt_q == '0)) begin
         head_d = mem_rdata;
      end
      valid_d = (cnt_d != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         tmo_q     <= '0;
         addr_q    <= '0;
         err_q     <= 1'b0;
         ws_q      <= 1'b1;
         mem_req_q <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         head_q    <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmo_q     <= tmo_d;
         addr_q    <= addr_d;
         err_q     <= err_d;
         ws_q      <= ws_d;
         mem_req_q <= mem_req_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         head_q    <= head_d;
         valid_q   <= valid_d;
      end
   end

   // Storage needs no reset; occupancy and pointers define what is live
   always_ff @(posedge clk) begin
      if (push_c) mem_q[wr_ptr_q] <= mem_rdata;
   end

   assign ws        = ws_q;
   assign mem_req   = mem_req_q;
   assign mem_addr  = addr_q;
   assign out_valid = valid_q;
   assign out_data  = head_q;
   assign err       = err_q;
   assign fifo_cnt  = cnt_q;

endmodule
